// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions (poly 0x8005, init 0xFFFF, MSB-first, one 16-bit word per update)
// used by both the transmit generator and the receive-side frame checker.
package crc16_pkg;

    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_t;

    // The loop unrolls into the 16-bit parallel next-state equations.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_word_update.sv
// Combinational one-word CRC-16 step; the transmit-side generator instantiates the same block.
module crc16_word_update
    import crc16_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [15:0] data,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_update(crc_in, data);

endmodule

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 checker: forwards payload, strips the trailing CRC word, reports a verdict.
// state    | meaning
// IDLE     | waiting for a sop word
// IN_FRAME | frame open, one payload word held back until the next word shows if it was last
module crc16_frame_checker
    import crc16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      s_data,
    input  logic             s_valid,
    input  logic             s_sop,
    input  logic             s_eop,
    output logic             s_ready,
    output logic [15:0]      m_data,
    output logic             m_valid,
    output logic             m_sop,
    output logic             m_eop,
    input  logic             m_ready,
    output logic             stat_valid,
    output logic             stat_ok,
    output logic             stat_abort,
    output logic [15:0]      crc_calc,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_base, crc_next, hold_data, verdict_crc;
    logic        hold_sop, hold_valid;
    logic        accept, start_frame, load_word, push_word, push_last, end_frame;
    logic        verdict, verdict_ok, verdict_abort;

    assign s_ready  = !rst && (!m_valid || m_ready);
    assign accept   = s_valid && s_ready;
    assign crc_base = start_frame ? CRC_INIT : crc_q;

    crc16_word_update u_update (
        .crc_in (crc_base),
        .data   (s_data),
        .crc_out(crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        start_frame   = 1'b0;
        load_word     = 1'b0;
        push_word     = 1'b0;
        push_last     = 1'b0;
        end_frame     = 1'b0;
        verdict       = 1'b0;
        verdict_ok    = 1'b0;
        verdict_abort = 1'b0;
        verdict_crc   = crc_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (s_sop && s_eop) begin
                        verdict     = 1'b1;
                        verdict_ok  = (s_data == CRC_INIT);
                        verdict_crc = CRC_INIT;
                    end else if (s_sop) begin
                        start_frame = 1'b1;
                        load_word   = 1'b1;
                        state_d     = IN_FRAME;
                    end
                end
                IN_FRAME: begin
                    if (s_eop) begin
                        push_word  = hold_valid;
                        push_last  = 1'b1;
                        end_frame  = 1'b1;
                        verdict    = 1'b1;
                        verdict_ok = (s_data == crc_q);
                        state_d    = IDLE;
                    end else if (s_sop) begin
                        // Abort: the held word is dropped and the new frame opens in the same cycle.
                        verdict       = 1'b1;
                        verdict_abort = 1'b1;
                        start_frame   = 1'b1;
                        load_word     = 1'b1;
                    end else begin
                        push_word = hold_valid;
                        load_word = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q      <= CRC_INIT;
            hold_data  <= '0;
            hold_sop   <= 1'b0;
            hold_valid <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_sop      <= 1'b0;
            m_eop      <= 1'b0;
            stat_valid <= 1'b0;
            stat_ok    <= 1'b0;
            stat_abort <= 1'b0;
            crc_calc   <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            if (load_word) begin
                crc_q      <= crc_next;
                hold_data  <= s_data;
                hold_sop   <= start_frame;
                hold_valid <= 1'b1;
            end else if (end_frame) begin
                hold_valid <= 1'b0;
            end

            if (push_word) begin
                m_valid <= 1'b1;
                m_data  <= hold_data;
                m_sop   <= hold_sop;
                m_eop   <= push_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_sop   <= 1'b0;
                m_eop   <= 1'b0;
            end

            stat_valid <= verdict;
            stat_ok    <= verdict_ok;
            stat_abort <= verdict_abort;
            if (verdict && !verdict_abort) crc_calc <= verdict_crc;
            if (verdict) begin
                if (verdict_ok) begin
                    if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
                end else begin
                    if (bad_cnt != '1) bad_cnt <= bad_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Scoreboard bench for crc16_frame_checker: expected words/verdicts queued at drive time,
// popped by a negedge monitor; a second narrow-counter instance exercises saturation.
module tb_crc16_frame_checker;

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } word_t;

    typedef struct packed {
        logic        ok;
        logic        abort;
        logic [15:0] crc;
        logic        chk_crc;
    } stat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid, s_sop, s_eop, s_ready;
    logic [15:0] m_data;
    logic        m_valid, m_sop, m_eop, m_ready;
    logic        stat_valid, stat_ok, stat_abort;
    logic [15:0] crc_calc, good_cnt, bad_cnt;

    logic [15:0] t_data;
    logic        t_valid, t_sop, t_eop, t_ready, t_mready;
    logic [15:0] t_mdata;
    logic        t_mvalid, t_msop, t_meop;
    logic        t_stat_valid, t_stat_ok, t_stat_abort;
    logic [15:0] t_crc_calc;
    logic [1:0]  t_good, t_bad;

    word_t       wq[$];
    stat_t       sq[$];
    word_t       mw;
    stat_t       ms;
    logic [15:0] exp_good, exp_bad;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc16_frame_checker dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
        .stat_valid(stat_valid), .stat_ok(stat_ok), .stat_abort(stat_abort),
        .crc_calc(crc_calc), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    crc16_frame_checker #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .s_data(t_data), .s_valid(t_valid), .s_sop(t_sop), .s_eop(t_eop), .s_ready(t_ready),
        .m_data(t_mdata), .m_valid(t_mvalid), .m_sop(t_msop), .m_eop(t_meop), .m_ready(t_mready),
        .stat_valid(t_stat_valid), .stat_ok(t_stat_ok), .stat_abort(t_stat_abort),
        .crc_calc(t_crc_calc), .good_cnt(t_good), .bad_cnt(t_bad)
    );

    // Reference CRC as polynomial long division: ((crc ^ d) * x^16) mod 0x18005.
    function automatic logic [15:0] model_update(input logic [15:0] crc, input logic [15:0] d);
        logic [31:0] v;
        v = {crc ^ d, 16'h0000};
        for (int i = 31; i >= 16; i--)
            if (v[i]) v = v ^ (32'h0001_8005 << (i - 16));
        return v[15:0];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got data=%h sop=%b eop=%b", m_data, m_sop, m_eop);
                end else begin
                    mw = wq.pop_front();
                    if ({m_data, m_sop, m_eop} !== {mw.data, mw.sop, mw.eop}) begin
                        errors++;
                        $display("FAIL payload got data=%h sop=%b eop=%b want data=%h sop=%b eop=%b",
                                 m_data, m_sop, m_eop, mw.data, mw.sop, mw.eop);
                    end
                end
            end
            if (stat_valid) begin
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_verdict got ok=%b abort=%b", stat_ok, stat_abort);
                end else begin
                    ms = sq.pop_front();
                    if (ms.ok) begin
                        if (exp_good != 16'hFFFF) exp_good = exp_good + 16'd1;
                    end else begin
                        if (exp_bad != 16'hFFFF) exp_bad = exp_bad + 16'd1;
                    end
                    if (stat_ok !== ms.ok || stat_abort !== ms.abort || (ms.chk_crc && crc_calc !== ms.crc)
                        || good_cnt !== exp_good || bad_cnt !== exp_bad) begin
                        errors++;
                        $display("FAIL verdict got ok=%b abort=%b crc=%h good=%0d bad=%0d want ok=%b abort=%b crc=%h good=%0d bad=%0d",
                                 stat_ok, stat_abort, crc_calc, good_cnt, bad_cnt,
                                 ms.ok, ms.abort, ms.crc, exp_good, exp_bad);
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [15:0] d, input logic sop, input logic eop);
        int n = 0;
        s_data  = d;
        s_sop   = sop;
        s_eop   = eop;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout got s_ready=%b want 1", s_ready);
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] pay [0:7], input int n, input logic [15:0] flip);
        logic [15:0] crc;
        crc = 16'hFFFF;
        for (int i = 0; i < n; i++) crc = model_update(crc, pay[i]);
        for (int i = 0; i < n; i++) wq.push_back('{pay[i], (i == 0), (i == n - 1)});
        sq.push_back('{(flip == 16'h0000), 1'b0, crc, 1'b1});
        for (int i = 0; i < n; i++) send_word(pay[i], (i == 0), 1'b0);
        send_word(crc ^ flip, (n == 0), 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((wq.size() != 0 || sq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (wq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL drain got words=%0d verdicts=%0d pending want 0", wq.size(), sq.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({m_valid, m_sop, m_eop, stat_valid, stat_ok, stat_abort, s_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000000",
                     {m_valid, m_sop, m_eop, stat_valid, stat_ok, stat_abort, s_ready});
        end
        checks++;
        if ({m_data, crc_calc, good_cnt, bad_cnt} !== 64'h0) begin
            errors++;
            $display("FAIL reset_values got data=%h crc=%h good=%0d bad=%0d want 0",
                     m_data, crc_calc, good_cnt, bad_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", s_ready);
        end
    endtask

    task automatic test_single_good();
        logic [15:0] pay [0:7] = '{16'h0000, 0, 0, 0, 0, 0, 0, 0};
        send_frame(pay, 1, 16'h0000);
        checks++;
        if ({m_valid, m_sop, m_eop, stat_valid} !== 4'b1111) begin
            errors++;
            $display("FAIL single_timing got valid/sop/eop/stat=%b want 1111",
                     {m_valid, m_sop, m_eop, stat_valid});
        end
        wait_drain();
        checks++;
        if (good_cnt !== 16'd1 || crc_calc !== 16'h800D) begin
            errors++;
            $display("FAIL single_counts got good=%0d crc=%h want good=1 crc=800d", good_cnt, crc_calc);
        end
    endtask

    task automatic test_zero_payload();
        logic [15:0] pay [0:7] = '{default: 16'h0000};
        send_frame(pay, 0, 16'h0000);
        checks++;
        if (stat_valid !== 1'b1 || stat_ok !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_payload got stat=%b ok=%b m_valid=%b want 1 1 0", stat_valid, stat_ok, m_valid);
        end
        wait_drain();
        checks++;
        if (good_cnt !== 16'd2) begin
            errors++;
            $display("FAIL zero_payload_cnt got good=%0d want 2", good_cnt);
        end
    endtask

    task automatic test_bad_crc();
        logic [15:0] pay [0:7] = '{16'h0000, 0, 0, 0, 0, 0, 0, 0};
        send_frame(pay, 1, 16'h0001);
        wait_drain();
        checks++;
        if (bad_cnt !== 16'd1 || crc_calc !== 16'h800D || good_cnt !== 16'd2) begin
            errors++;
            $display("FAIL bad_crc got bad=%0d good=%0d crc=%h want bad=1 good=2 crc=800d",
                     bad_cnt, good_cnt, crc_calc);
        end
    endtask

    task automatic test_stall();
        logic [15:0] w [0:3] = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hFFFF};
        logic [15:0] crc;
        crc = 16'hFFFF;
        for (int i = 0; i < 4; i++) crc = model_update(crc, w[i]);
        for (int i = 0; i < 4; i++) wq.push_back('{w[i], (i == 0), (i == 3)});
        sq.push_back('{1'b1, 1'b0, crc, 1'b1});
        send_word(w[0], 1'b1, 1'b0);
        s_data = w[1]; s_sop = 1'b0; s_eop = 1'b0; s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_data  = w[2];
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== w[0]) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got s_ready=%b m_valid=%b m_data=%h want 0 1 %h",
                         k, s_ready, m_valid, m_data, w[0]);
            end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send_word(w[2], 1'b0, 1'b0);
        send_word(w[3], 1'b0, 1'b0);
        send_word(crc, 1'b0, 1'b1);
        wait_drain();
    endtask

    task automatic test_abort();
        logic [15:0] crc;
        crc = model_update(model_update(16'hFFFF, 16'h3333), 16'h4444);
        wq.push_back('{16'h1111, 1'b1, 1'b0});
        wq.push_back('{16'h3333, 1'b1, 1'b0});
        wq.push_back('{16'h4444, 1'b0, 1'b1});
        sq.push_back('{1'b0, 1'b1, 16'h0000, 1'b0});
        sq.push_back('{1'b1, 1'b0, crc, 1'b1});
        send_word(16'h1111, 1'b1, 1'b0);
        send_word(16'h2222, 1'b0, 1'b0);
        send_word(16'h3333, 1'b1, 1'b0);
        checks++;
        if ({stat_valid, stat_ok, stat_abort} !== 3'b101) begin
            errors++;
            $display("FAIL abort_pulse got valid/ok/abort=%b want 101", {stat_valid, stat_ok, stat_abort});
        end
        send_word(16'h4444, 1'b0, 1'b0);
        send_word(crc, 1'b0, 1'b1);
        wait_drain();
        checks++;
        if (bad_cnt !== 16'd2) begin
            errors++;
            $display("FAIL abort_cnt got bad=%0d want 2", bad_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p2 [0:7] = '{16'h0001, 16'h0002, 0, 0, 0, 0, 0, 0};
        logic [15:0] p0 [0:7] = '{default: 16'h0000};
        logic [15:0] p1 [0:7] = '{16'hBEEF, 0, 0, 0, 0, 0, 0, 0};
        int c0;
        c0 = cyc;
        send_frame(p2, 2, 16'h0000);
        send_frame(p0, 0, 16'h0000);
        send_frame(p1, 1, 16'h0100);
        checks++;
        if (cyc - c0 !== 6) begin
            errors++;
            $display("FAIL back_to_back_cycles got %0d want 6", cyc - c0);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] pay [0:7] = '{16'h0000, 0, 0, 0, 0, 0, 0, 0};
        send_word(16'h5555, 1'b1, 1'b0);
        rst = 1'b1;
        exp_good = 16'h0000;
        exp_bad  = 16'h0000;
        #1;
        checks++;
        if ({m_valid, stat_valid, s_ready, good_cnt, bad_cnt, crc_calc, m_data} !== 67'h0) begin
            errors++;
            $display("FAIL mid_reset got m_valid=%b stat=%b s_ready=%b good=%0d bad=%0d crc=%h data=%h want all 0",
                     m_valid, stat_valid, s_ready, good_cnt, bad_cnt, crc_calc, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(pay, 1, 16'h0000);
        wait_drain();
        checks++;
        if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_cnt got good=%0d bad=%0d want 1 0", good_cnt, bad_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        for (int k = 0; k < 4; k++) begin
            t_data = 16'h0000; t_sop = 1'b1; t_eop = 1'b1; t_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            t_valid = 1'b0;
            want = (k < 3) ? 2'(k + 1) : 2'b11;
            checks++;
            if (t_stat_valid !== 1'b1 || t_stat_ok !== 1'b0 || t_bad !== want || t_good !== 2'b00) begin
                errors++;
                $display("FAIL saturation frame %0d got stat=%b ok=%b bad=%0d good=%0d want 1 0 %0d 0",
                         k, t_stat_valid, t_stat_ok, t_bad, t_good, want);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        s_data = '0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; m_ready = 1'b1;
        t_data = '0; t_valid = 1'b0; t_sop = 1'b0; t_eop = 1'b0; t_mready = 1'b1;
        exp_good = 16'h0000;
        exp_bad  = 16'h0000;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_good();
        test_zero_payload();
        test_bad_crc();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
